// File: rtl/mem_access_ctrl_if.sv
// Data-bus bundle between the MEM-stage access controller and the memory side.
interface mem_access_ctrl_if #(
   parameter int XLEN = 64
);
   logic                dbus_valid;
   logic                dbus_ready;
   logic [XLEN-1:0]     dbus_addr;
   logic                dbus_write;
   logic [XLEN/8-1:0]   dbus_strobe;
   logic [XLEN-1:0]     dbus_wdata;
   logic                dbus_resp_valid;
   logic [XLEN-1:0]     dbus_resp_data;

   modport master (
      output dbus_valid, dbus_addr, dbus_write, dbus_strobe, dbus_wdata,
      input  dbus_ready, dbus_resp_valid, dbus_resp_data
   );

   modport slave (
      input  dbus_valid, dbus_addr, dbus_write, dbus_strobe, dbus_wdata,
      output dbus_ready, dbus_resp_valid, dbus_resp_data
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one dbus transaction per op, stalls the
// pipeline until it completes, returns the extended load result, flags
// misaligned accesses and bus timeouts. Byte-lane math assumes 8-byte words.
module mem_access_ctrl #(
   parameter int XLEN     = 64,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic              flush,
   output logic              stall,
   output logic              done,
   output logic [XLEN-1:0]   rdata,
   output logic              misalign,
   output logic              bus_err,
   mem_access_ctrl_if.master dbus
);
   localparam int SB = XLEN / 8;
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_t;

   state_t            state_q;
   logic              kill_q;
   logic [CW-1:0]     wait_cnt_q;
   logic [2:0]        off_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic              write_q;
   logic              valid_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [SB-1:0]     strb_q;
   logic [XLEN-1:0]   rdata_q;
   logic              misalign_q;
   logic              bus_err_q;

   logic              aligned;
   logic [SB-1:0]     strb_base;
   logic [SB-1:0]     strb_d;
   logic [XLEN-1:0]   wdata_d;
   logic [XLEN-1:0]   ld_sh;
   logic [XLEN-1:0]   ld_d;
   logic              timeout;
   logic              drop;

   // Alignment check and lane placement of the incoming request
   always_comb begin
      case (req_size)
         2'd0:    begin aligned = 1'b1;                     strb_base = SB'(8'h01); end
         2'd1:    begin aligned = ~req_addr[0];             strb_base = SB'(8'h03); end
         2'd2:    begin aligned = (req_addr[1:0] == 2'b00); strb_base = SB'(8'h0F); end
         default: begin aligned = (req_addr[2:0] == 3'b000); strb_base = SB'(8'hFF); end
      endcase
      strb_d  = strb_base << req_addr[2:0];
      wdata_d = req_wdata << {req_addr[2:0], 3'b000};
   end

   // Load data: bring the addressed lane down to bit 0, truncate, extend
   always_comb begin
      ld_sh = dbus.dbus_resp_data >> {off_q, 3'b000};
      case (size_q)
         2'd0:    ld_d = {{(XLEN-8){~uns_q & ld_sh[7]}},   ld_sh[7:0]};
         2'd1:    ld_d = {{(XLEN-16){~uns_q & ld_sh[15]}}, ld_sh[15:0]};
         2'd2:    ld_d = {{(XLEN-32){~uns_q & ld_sh[31]}}, ld_sh[31:0]};
         default: ld_d = ld_sh;
      endcase
   end

   // Counter may overshoot LAST by one when a handshake lands on the last cycle
   assign timeout = (wait_cnt_q >= LAST);
   assign drop    = kill_q | flush;

   // Control FSM with registered bus and result outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         kill_q     <= 1'b0;
         wait_cnt_q <= '0;
         off_q      <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         write_q    <= 1'b0;
         valid_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         strb_q     <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid && !flush) begin
                  if (aligned) begin
                     addr_q     <= {req_addr[XLEN-1:3], 3'b000};
                     wdata_q    <= wdata_d;
                     strb_q     <= strb_d;
                     write_q    <= req_write;
                     off_q      <= req_addr[2:0];
                     size_q     <= req_size;
                     uns_q      <= req_unsigned;
                     valid_q    <= 1'b1;
                     wait_cnt_q <= '0;
                     kill_q     <= 1'b0;
                     state_q    <= S_ISSUE;
                  end else begin
                     misalign_q <= 1'b1;
                     state_q    <= S_DONE;
                  end
               end
            end
            S_ISSUE: begin
               if (dbus.dbus_ready) begin
                  valid_q    <= 1'b0;
                  wait_cnt_q <= wait_cnt_q + CW'(1);
                  kill_q     <= 1'b0;
                  state_q    <= drop ? S_DRAIN : S_WAIT;
               end else if (timeout) begin
                  valid_q    <= 1'b0;
                  kill_q     <= 1'b0;
                  bus_err_q  <= ~drop;
                  state_q    <= drop ? S_IDLE : S_DONE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CW'(1);
                  if (flush) kill_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (flush) begin
                  wait_cnt_q <= wait_cnt_q + CW'(1);
                  state_q    <= dbus.dbus_resp_valid ? S_IDLE : S_DRAIN;
               end else if (dbus.dbus_resp_valid) begin
                  rdata_q <= write_q ? '0 : ld_d;
                  state_q <= S_DONE;
               end else if (timeout) begin
                  bus_err_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CW'(1);
               end
            end
            S_DRAIN: begin
               if (dbus.dbus_resp_valid || timeout) state_q <= S_IDLE;
               else                                 wait_cnt_q <= wait_cnt_q + CW'(1);
            end
            S_DONE: begin
               rdata_q    <= '0;
               misalign_q <= 1'b0;
               bus_err_q  <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // A request waiting in IDLE must hold the pipeline; DONE releases it
   assign stall = (state_q == S_IDLE) ? (req_valid & ~flush) : (state_q != S_DONE);
   assign done  = (state_q == S_DONE) & ~flush;

   assign rdata    = rdata_q;
   assign misalign = misalign_q;
   assign bus_err  = bus_err_q;

   assign dbus.dbus_valid  = valid_q;
   assign dbus.dbus_addr   = addr_q;
   assign dbus.dbus_write  = write_q;
   assign dbus.dbus_strobe = strb_q;
   assign dbus.dbus_wdata  = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed table, random ops against a byte-level
// model, and hand sequences for flush / reset / late-response corners.
module tb_mem_access_ctrl;
   localparam int XLEN     = 64;
   localparam int MAX_WAIT = 255;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_valid, req_write, req_unsigned, flush;
   logic [XLEN-1:0]   req_addr, req_wdata;
   logic [1:0]        req_size;
   logic              stall, done, misalign, bus_err;
   logic [XLEN-1:0]   rdata;

   int total = 0;
   int bad   = 0;

   mem_access_ctrl_if #(.XLEN(XLEN)) dbus ();

   mem_access_ctrl #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .flush(flush), .stall(stall), .done(done), .rdata(rdata),
      .misalign(misalign), .bus_err(bus_err), .dbus(dbus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      string       nm;
      logic        wr;
      logic [63:0] addr;
      logic [1:0]  sz;
      logic        uns;
      logic [63:0] wd;
      logic [63:0] rd;
      int          rdy;
      int          rsp;
      logic [63:0] e_rdata;
      logic [7:0]  e_strb;
      logic [63:0] e_wd;
      logic        e_mis;
      logic        e_err;
      int          e_lat;
   } op_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Byte-level reference: gather the addressed bytes, then extend
   function automatic logic [63:0] model_load(input logic [63:0] d, input int off,
                                              input int n, input logic uns);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
      if (!uns && n < 8 && v[8*n-1])
         for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic op_t mk(input string nm, input logic wr, input logic [63:0] addr,
                              input logic [1:0] sz, input logic uns, input logic [63:0] wd,
                              input logic [63:0] rd, input int rdy, input int rsp);
      op_t o;
      int n   = 1 << sz;
      int off = int'(addr % 8);
      o.nm = nm; o.wr = wr; o.addr = addr; o.sz = sz; o.uns = uns;
      o.wd = wd; o.rd = rd; o.rdy = rdy; o.rsp = rsp;
      o.e_mis  = (addr % n) != 0;
      o.e_err  = !o.e_mis && (rdy + 1 + rsp > MAX_WAIT - 1);
      o.e_strb = '0;
      for (int i = 0; i < n && off + i < 8; i++) o.e_strb[off+i] = 1'b1;
      o.e_wd    = wd << (8 * off);
      o.e_rdata = (o.e_mis || o.e_err || wr) ? 64'h0 : model_load(rd, off, n, uns);
      o.e_lat   = o.e_mis ? 1 : (o.e_err ? 1 + MAX_WAIT : 3 + rdy + rsp);
      return o;
   endfunction

   // Drives one op from the IDLE cycle and plays the bus slave until done.
   // Entered and left just after a rising edge.
   task automatic run_op(input op_t o);
      int cyc = 0, hs_cyc = 0, vcnt = 0, lat = -1;
      bit got_done = 0, vseen = 0, unstable = 0, stall_bad = 0, hs = 0;
      logic [63:0] a0 = '0, w0 = '0;
      logic [7:0]  s0 = '0;
      req_valid = 1'b1; req_write = o.wr; req_addr = o.addr; req_size = o.sz;
      req_unsigned = o.uns; req_wdata = o.wd; flush = 1'b0;
      dbus.dbus_resp_data = o.rd;
      while (!got_done && cyc < 600) begin
         if (cyc > 0) req_valid = 1'b0;
         dbus.dbus_ready      = dbus.dbus_valid && !hs && (vcnt >= o.rdy);
         dbus.dbus_resp_valid = hs && (cyc == hs_cyc + 1 + o.rsp);
         @(negedge clk);
         if (dbus.dbus_valid) begin
            if (!vseen) begin
               vseen = 1;
               a0 = dbus.dbus_addr; s0 = dbus.dbus_strobe; w0 = dbus.dbus_wdata;
               chk({o.nm, " addr"},   a0, o.addr & ~64'h7);
               chk({o.nm, " strobe"}, s0, o.e_strb);
               chk({o.nm, " wdata"},  w0, o.e_wd);
               chk({o.nm, " write"},  dbus.dbus_write, o.wr);
            end else if (dbus.dbus_addr !== a0 || dbus.dbus_strobe !== s0 ||
                         dbus.dbus_wdata !== w0) begin
               unstable = 1;
            end
            vcnt++;
            if (dbus.dbus_ready) begin hs = 1; hs_cyc = cyc; end
         end
         if (done) begin
            got_done = 1; lat = cyc;
            chk({o.nm, " rdata"},    rdata,    o.e_rdata);
            chk({o.nm, " misalign"}, misalign, o.e_mis);
            chk({o.nm, " bus_err"},  bus_err,  o.e_err);
            if (stall !== 1'b0) stall_bad = 1;
         end else if (stall !== 1'b1) begin
            stall_bad = 1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      dbus.dbus_ready = 1'b0; dbus.dbus_resp_valid = 1'b0; req_valid = 1'b0;
      chk({o.nm, " done latency"}, 64'(lat), 64'(o.e_lat));
      chk({o.nm, " stall profile ok"}, stall_bad, 1'b0);
      chk({o.nm, " bus request stable"}, unstable, 1'b0);
      chk({o.nm, " bus request issued"}, vseen, !o.e_mis);
   endtask

   // One cycle of a hand sequence: inputs already set, check, advance
   task automatic cyc_chk(input string nm, input logic es, input logic ed);
      @(negedge clk);
      chk({nm, " stall"}, stall, es);
      chk({nm, " done"},  done,  ed);
      @(posedge clk); #1;
   endtask

   task automatic set_req(input logic [63:0] a, input logic [1:0] sz);
      req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_size = sz;
      req_unsigned = 1'b0; req_wdata = '0;
   endtask

   op_t tbl[13];

   initial begin
      tbl[0]  = '{"lw",     0, 64'h1004, 2, 0, 0, 64'h80000000_12345678, 0, 0,
                  64'hFFFFFFFF_80000000, 8'hF0, 0, 0, 0, 3};
      tbl[1]  = '{"sb",     1, 64'h2003, 0, 0, 64'hAB, 0, 0, 0,
                  0, 8'h08, 64'hAB000000, 0, 0, 3};
      tbl[2]  = '{"lh_mis", 0, 64'h3001, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1};
      tbl[3]  = '{"lbu",    0, 64'h0010, 0, 1, 0, 64'h11223344_55667788, 1, 2,
                  64'h88, 8'h01, 0, 0, 0, 6};
      tbl[4]  = '{"lb",     0, 64'h0017, 0, 0, 0, 64'h80000000_00000000, 0, 0,
                  64'hFFFFFFFF_FFFFFF80, 8'h80, 0, 0, 0, 3};
      tbl[5]  = '{"ld",     0, 64'h0018, 3, 0, 0, 64'hDEADBEEF_CAFEF00D, 2, 3,
                  64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 0, 8};
      tbl[6]  = '{"lhu",    0, 64'h0022, 1, 1, 0, 64'h00000000_9ABC0000, 0, 0,
                  64'h9ABC, 8'h0C, 0, 0, 0, 3};
      tbl[7]  = '{"lw_mis", 0, 64'h1006, 2, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1};
      tbl[8]  = '{"ld_mis", 0, 64'h1004, 3, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1};
      tbl[9]  = '{"sd",     1, 64'h0040, 3, 0, 64'h01234567_89ABCDEF, 64'h55, 3, 0,
                  0, 8'hFF, 64'h01234567_89ABCDEF, 0, 0, 6};
      tbl[10] = '{"timeout", 0, 64'h0500, 3, 0, 0, 0, 1000, 0,
                  0, 8'hFF, 0, 0, 1, 1 + MAX_WAIT};
      tbl[11] = '{"lwu",    0, 64'h0104, 2, 1, 0, 64'h89ABCDEF_00000000, 1, 0,
                  64'h89ABCDEF, 8'hF0, 0, 0, 0, 4};
      tbl[12] = '{"lh",     0, 64'h0106, 1, 0, 0, 64'h80010000_00000000, 0, 1,
                  64'hFFFFFFFF_FFFF8001, 8'hC0, 0, 0, 0, 4};

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
      req_unsigned = 1'b0; req_wdata = '0; flush = 1'b0;
      dbus.dbus_ready = 1'b0; dbus.dbus_resp_valid = 1'b0; dbus.dbus_resp_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset stall", stall, 0);
      chk("reset done", done, 0);
      chk("reset rdata", rdata, 0);
      chk("reset flags", {misalign, bus_err}, 0);
      chk("reset dbus_valid", dbus.dbus_valid, 0);
      chk("reset dbus_addr", dbus.dbus_addr, 0);
      chk("reset dbus_strobe/write", {dbus.dbus_strobe, dbus.dbus_write}, 0);
      chk("reset dbus_wdata", dbus.dbus_wdata, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) run_op(tbl[i]);

      // late response after a timeout is dropped
      run_op(tbl[10]);
      dbus.dbus_resp_valid = 1'b1;
      cyc_chk("late0", 0, 0);
      dbus.dbus_resp_valid = 1'b0;
      cyc_chk("late1", 0, 0);

      // back-to-back LBU then LD with random bus delays
      run_op(mk("b2b_lbu", 0, 64'h10, 0, 1, 0, 64'hFEDCBA98_765432F1,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5))));
      run_op(mk("b2b_ld", 0, 64'h18, 3, 0, 0, 64'h0F1E2D3C_4B5A6978,
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5))));

      // random ops against the model
      for (int i = 0; i < 60; i++) begin
         logic [1:0]  sz = 2'($urandom_range(0, 3));
         logic [63:0] a  = 64'h1000 + 64'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << sz) - 1);
         run_op(mk("rnd", 1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4))));
      end

      // flush in WAIT: stall until response, no done
      set_req(64'h100, 2);
      cyc_chk("fw0", 1, 0);
      req_valid = 1'b0; dbus.dbus_ready = 1'b1;
      cyc_chk("fw1", 1, 0);
      dbus.dbus_ready = 1'b0; flush = 1'b1;
      cyc_chk("fw2", 1, 0);
      flush = 1'b0;
      cyc_chk("fw3", 1, 0);
      cyc_chk("fw4", 1, 0);
      dbus.dbus_resp_valid = 1'b1;
      cyc_chk("fw5", 1, 0);
      dbus.dbus_resp_valid = 1'b0;
      cyc_chk("fw6", 0, 0);
      cyc_chk("fw7", 0, 0);

      // flush in ISSUE: request stays up until accepted, then drains
      set_req(64'h200, 3);
      cyc_chk("fi0", 1, 0);
      req_valid = 1'b0; flush = 1'b1;
      cyc_chk("fi1", 1, 0);
      flush = 1'b0;
      @(negedge clk);
      chk("fi2 valid held", dbus.dbus_valid, 1);
      @(posedge clk); #1;
      dbus.dbus_ready = 1'b1;
      cyc_chk("fi3", 1, 0);
      dbus.dbus_ready = 1'b0; dbus.dbus_resp_valid = 1'b1;
      cyc_chk("fi4", 1, 0);
      dbus.dbus_resp_valid = 1'b0;
      cyc_chk("fi5", 0, 0);

      // flush together with response in WAIT: flush wins
      set_req(64'h300, 2);
      cyc_chk("fr0", 1, 0);
      req_valid = 1'b0; dbus.dbus_ready = 1'b1;
      cyc_chk("fr1", 1, 0);
      dbus.dbus_ready = 1'b0; flush = 1'b1; dbus.dbus_resp_valid = 1'b1;
      cyc_chk("fr2", 1, 0);
      flush = 1'b0; dbus.dbus_resp_valid = 1'b0;
      cyc_chk("fr3", 0, 0);
      cyc_chk("fr4", 0, 0);

      // flush in IDLE: nothing captured
      set_req(64'h400, 3); flush = 1'b1;
      cyc_chk("fidle0", 0, 0);
      req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("fidle1 no bus", {dbus.dbus_valid, stall, done}, 0);
      @(posedge clk); #1;

      // flush in DONE suppresses the pulse
      set_req(64'h3001, 1);
      cyc_chk("fdone0", 1, 0);
      req_valid = 1'b0; flush = 1'b1;
      cyc_chk("fdone1", 0, 0);
      flush = 1'b0;
      cyc_chk("fdone2", 0, 0);

      // reset mid-transaction returns straight to IDLE
      set_req(64'h600, 3);
      cyc_chk("rst0", 1, 0);
      req_valid = 1'b0; dbus.dbus_ready = 1'b1;
      cyc_chk("rst1", 1, 0);
      dbus.dbus_ready = 1'b0; reset = 1'b1;
      cyc_chk("rst2", 1, 0);
      reset = 1'b0; dbus.dbus_resp_valid = 1'b1;
      @(negedge clk);
      chk("rst3 idle", {dbus.dbus_valid, stall, done}, 0);
      @(posedge clk); #1;
      dbus.dbus_resp_valid = 1'b0;
      cyc_chk("rst4", 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
